// File: rtl/spi_pkg.sv
// Shared types and width helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SCLK_HIGH,
    SCLK_LOW,
    CS_WAIT,
    DONE
  } state_t;

  localparam int FREQ_W = 3;
  // Wide enough to count to the largest half-period, 2^7 cycles.
  localparam int DIV_W  = 8;

  function automatic int size_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int cs_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear; clear wins over increment.
module counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/shiftreg.sv
// Loadable left-shift register; the serial input enters at the LSB.
module shiftreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[W-2:0], shift_in};
    end
  end

endmodule

// File: rtl/spi_master_param_ctrl.sv
// Transaction FSM and SCLK divider; drives sclk, ready and valid, plus datapath strobes.
module spi_master_param_ctrl
  import spi_pkg::*;
#(
  parameter int SW = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              recv_val,
  input  logic              send_rdy,
  input  logic [FREQ_W-1:0] freq,
  input  logic [SW-1:0]     bit_cnt,
  input  logic [SW-1:0]     size,
  output logic              idle_rdy,
  output logic              send_val,
  output logic              sclk,
  output logic              load_en,
  output logic              shift_en,
  output logic              finish_en
);

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] half_m1;
  logic             phase_end;

  assign half_m1   = (DIV_W'(1) << freq) - DIV_W'(1);
  assign phase_end = (div_reg == half_m1);

  assign load_en   = (state_reg == IDLE) && recv_val;
  assign shift_en  = (state_reg == SCLK_HIGH) && phase_end;
  assign finish_en = (state_reg == CS_WAIT) && phase_end;

  // Every transition clears the divider so each phase lasts exactly H cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      idle_rdy  <= 1'b1;
      send_val  <= 1'b0;
      sclk      <= 1'b0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
      case (state_reg)
        IDLE: begin
          if (recv_val) begin
            state_reg <= START;
            div_reg   <= '0;
            idle_rdy  <= 1'b0;
          end
        end
        START: begin
          if (phase_end) begin
            state_reg <= SCLK_HIGH;
            div_reg   <= '0;
            sclk      <= 1'b1;
          end
        end
        SCLK_HIGH: begin
          if (phase_end) begin
            state_reg <= SCLK_LOW;
            div_reg   <= '0;
            sclk      <= 1'b0;
          end
        end
        SCLK_LOW: begin
          if (phase_end) begin
            div_reg <= '0;
            if (bit_cnt == size) begin
              state_reg <= CS_WAIT;
            end else begin
              state_reg <= SCLK_HIGH;
              sclk      <= 1'b1;
            end
          end
        end
        CS_WAIT: begin
          if (phase_end) begin
            state_reg <= DONE;
            div_reg   <= '0;
            send_val  <= 1'b1;
          end
        end
        DONE: begin
          if (send_rdy) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            send_val  <= 1'b0;
            idle_rdy  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          div_reg   <= '0;
          idle_rdy  <= 1'b1;
          send_val  <= 1'b0;
          sclk      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Mode-0 SPI master with per-transaction packet size, one-hot chip select and SCLK divider.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int nbits = 34,
  parameter int ncs   = 1,
  localparam int SW   = size_w(nbits),
  localparam int CW   = cs_w(ncs)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              recv_val,
  output logic              recv_rdy,
  input  logic [nbits-1:0]  recv_msg,
  output logic              send_val,
  input  logic              send_rdy,
  output logic [nbits-1:0]  send_msg,
  input  logic              packet_size_val,
  output logic              packet_size_rdy,
  input  logic [SW-1:0]     packet_size_msg,
  input  logic              cs_addr_val,
  output logic              cs_addr_rdy,
  input  logic [CW-1:0]     cs_addr_msg,
  input  logic              freq_val,
  output logic              freq_rdy,
  input  logic [FREQ_W-1:0] freq_msg,
  output logic [ncs-1:0]    cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [SW-1:0] NBITS_SZ = SW'(nbits);
  localparam logic [CW:0]   NCS_V    = (CW + 1)'(ncs);

  logic [SW-1:0]     packet_size_reg, active_size_reg, size_clean;
  logic [CW-1:0]     cs_addr_reg, active_cs_reg, cs_clean;
  logic [FREQ_W-1:0] freq_reg, active_freq_reg;
  logic [ncs-1:0]    cs_reg;
  logic [nbits-1:0]  tx_load, tx_q, rx_q;
  logic [SW-1:0]     bit_cnt;
  logic              idle_rdy, load_en, shift_en, finish_en;
  logic              unused_tx_bits;

  assign recv_rdy        = idle_rdy;
  assign packet_size_rdy = idle_rdy;
  assign cs_addr_rdy     = idle_rdy;
  assign freq_rdy        = idle_rdy;

  always_comb begin
    size_clean = packet_size_msg;
    if (packet_size_msg == '0 || packet_size_msg > NBITS_SZ) begin
      size_clean = NBITS_SZ;
    end
    cs_clean = cs_addr_msg;
    if ({1'b0, cs_addr_msg} >= NCS_V) begin
      cs_clean = '0;
    end
  end

  // Left-align the packet so its first bit sits at the MSB, which drives mosi.
  assign tx_load = recv_msg << (NBITS_SZ - packet_size_reg);

  // The transaction runs on the active_* copies, so a config write that fires
  // alongside recv only takes effect on the following transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      packet_size_reg <= NBITS_SZ;
      cs_addr_reg     <= '0;
      freq_reg        <= '0;
      active_size_reg <= NBITS_SZ;
      active_cs_reg   <= '0;
      active_freq_reg <= '0;
      cs_reg          <= '1;
    end else begin
      if (load_en) begin
        active_size_reg <= packet_size_reg;
        active_cs_reg   <= cs_addr_reg;
        active_freq_reg <= freq_reg;
        cs_reg          <= ~(ncs'(1) << cs_addr_reg);
      end else if (finish_en) begin
        cs_reg <= '1;
      end
      if (idle_rdy && packet_size_val) packet_size_reg <= size_clean;
      if (idle_rdy && cs_addr_val)     cs_addr_reg     <= cs_clean;
      if (idle_rdy && freq_val)        freq_reg        <= freq_msg;
    end
  end

  spi_master_param_ctrl #(.SW(SW)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .recv_val  (recv_val),
    .send_rdy  (send_rdy),
    .freq      (active_freq_reg),
    .bit_cnt   (bit_cnt),
    .size      (active_size_reg),
    .idle_rdy  (idle_rdy),
    .send_val  (send_val),
    .sclk      (sclk),
    .load_en   (load_en),
    .shift_en  (shift_en),
    .finish_en (finish_en)
  );

  shiftreg #(.W(nbits)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_data (tx_load),
    .shift_en  (shift_en),
    .shift_in  (1'b0),
    .q         (tx_q)
  );

  shiftreg #(.W(nbits)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_data ('0),
    .shift_en  (shift_en),
    .shift_in  (miso),
    .q         (rx_q)
  );

  counter #(.W(SW)) u_bits (
    .clk   (clk),
    .reset (reset),
    .clr   (load_en),
    .inc   (shift_en),
    .q     (bit_cnt)
  );

  assign cs             = cs_reg;
  assign mosi           = tx_q[nbits-1];
  assign unused_tx_bits = ^tx_q[nbits-2:0];

  genvar gi;
  generate
    for (gi = 0; gi < nbits; gi++) begin : g_mask
      assign send_msg[gi] = rx_q[gi] & (SW'(gi) < active_size_reg);
    end
  endgenerate

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: loopback, divider, chip select, size bounds, backpressure, reset.
module tb_spi_master_param;

  localparam int NB  = 34;
  localparam int NCS = 4;
  localparam int SW  = 7;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          recv_val = 1'b0, recv_rdy;
  logic [NB-1:0] recv_msg = '0;
  logic          send_val, send_rdy = 1'b0;
  logic [NB-1:0] send_msg;
  logic          packet_size_val = 1'b0, packet_size_rdy;
  logic [SW-1:0] packet_size_msg = '0;
  logic          cs_addr_val = 1'b0, cs_addr_rdy;
  logic [CW-1:0] cs_addr_msg = '0;
  logic          freq_val = 1'b0, freq_rdy;
  logic [2:0]    freq_msg = '0;
  logic [NCS-1:0] cs;
  logic          sclk, mosi, miso;

  logic          loop_mode = 1'b1;
  logic [NB-1:0] fol_reg = '0;
  logic [NB-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  // Follower model: presents its MSB, advances on each falling sclk.
  assign miso = loop_mode ? mosi : fol_reg[NB-1];
  always @(negedge sclk) fol_reg = fol_reg << 1;

  spi_master_param #(.nbits(NB), .ncs(NCS)) dut (
    .clk             (clk),
    .reset           (reset),
    .recv_val        (recv_val),
    .recv_rdy        (recv_rdy),
    .recv_msg        (recv_msg),
    .send_val        (send_val),
    .send_rdy        (send_rdy),
    .send_msg        (send_msg),
    .packet_size_val (packet_size_val),
    .packet_size_rdy (packet_size_rdy),
    .packet_size_msg (packet_size_msg),
    .cs_addr_val     (cs_addr_val),
    .cs_addr_rdy     (cs_addr_rdy),
    .cs_addr_msg     (cs_addr_msg),
    .freq_val        (freq_val),
    .freq_rdy        (freq_rdy),
    .freq_msg        (freq_msg),
    .cs              (cs),
    .sclk            (sclk),
    .mosi            (mosi),
    .miso            (miso)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [SW-1:0] ps, input logic [CW-1:0] ca, input logic [2:0] fq);
    @(negedge clk);
    chk("cfg_rdy", {packet_size_rdy, cs_addr_rdy, freq_rdy}, 3'b111);
    packet_size_val = 1'b1; packet_size_msg = ps;
    cs_addr_val     = 1'b1; cs_addr_msg     = ca;
    freq_val        = 1'b1; freq_msg        = fq;
    @(posedge clk);
    #1;
    packet_size_val = 1'b0; cs_addr_val = 1'b0; freq_val = 1'b0;
  endtask

  task automatic xfer(input string name, input logic [NB-1:0] msg, input logic [NB-1:0] exp,
                      input int p, input int h, input logic [NCS-1:0] cs_exp, input int hold,
                      input bit ps_wr, input logic [SW-1:0] ps_new);
    int n, pulses, run, bad_high;
    logic prev, cs_ok, stable;
    logic [NB-1:0] snap, e;
    @(negedge clk);
    chk({name, "_recv_rdy"}, recv_rdy, 1);
    recv_val = 1'b1; recv_msg = msg;
    packet_size_val = ps_wr; packet_size_msg = ps_new;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    recv_val = 1'b0; packet_size_val = 1'b0;
    n = 0; pulses = 0; run = 0; bad_high = 0; prev = 1'b0; cs_ok = 1'b1;
    while (n < 5000) begin
      @(negedge clk);
      n++;
      if (send_val) break;
      if (cs !== cs_exp) cs_ok = 1'b0;
      if (sclk) begin
        if (!prev) pulses++;
        run++;
      end else begin
        if (prev && run != h) bad_high++;
        run = 0;
      end
      prev = sclk;
    end
    chk({name, "_done"}, send_val, 1);
    chk({name, "_latency"}, n, 1 + 2 * h * (p + 1));
    chk({name, "_pulses"}, pulses, p);
    chk({name, "_high_len_errs"}, bad_high, 0);
    chk({name, "_cs_active"}, cs_ok, 1);
    chk({name, "_cs_done"}, cs, 4'hF);
    if (hold > 0) begin
      snap = send_msg;
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!send_val || send_msg !== snap || recv_rdy) stable = 1'b0;
      end
      chk({name, "_backpressure_stable"}, stable, 1);
    end
    e = exp_q.pop_front();
    chk({name, "_msg"}, send_msg, e);
    $display("xfer %s: sent 0x%0h got 0x%0h expected 0x%0h latency %0d pulses %0d",
             name, msg, send_msg, e, n, pulses);
    send_rdy = 1'b1;
    @(posedge clk);
    #1;
    send_rdy = 1'b0;
    @(negedge clk);
    chk({name, "_back_idle"}, {send_val, recv_rdy}, 2'b01);
  endtask

  initial begin : main
    int pulses, n;
    logic prev, saw_val;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cs", cs, 4'hF);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_send_val", send_val, 0);
    chk("rst_recv_rdy", recv_rdy, 1);

    cfg(7'd8, 2'd0, 3'd0);
    xfer("loopback", 34'hA5, 34'hA5, 8, 1, 4'b1110, 0, 1'b0, '0);

    cfg(7'd4, 2'd0, 3'd2);
    loop_mode = 1'b0;
    fol_reg = 34'h6 << 30;
    xfer("divider", 34'h9, 34'h6, 4, 4, 4'b1110, 0, 1'b0, '0);
    loop_mode = 1'b1;

    cfg(7'd4, 2'd2, 3'd0);
    xfer("cs2", 34'h5, 34'h5, 4, 1, 4'b1011, 0, 1'b0, '0);
    cfg(7'd4, 2'd3, 3'd0);
    xfer("cs3", 34'hA, 34'hA, 4, 1, 4'b0111, 0, 1'b0, '0);

    cfg(7'd0, 2'd0, 3'd0);
    xfer("p0_full", 34'h2_0000_0001, 34'h2_0000_0001, 34, 1, 4'b1110, 0, 1'b0, '0);
    cfg(7'd40, 2'd0, 3'd0);
    xfer("p40_full", 34'h3_0F0F_5A5A, 34'h3_0F0F_5A5A, 34, 1, 4'b1110, 0, 1'b0, '0);

    cfg(7'd8, 2'd0, 3'd0);
    xfer("bp_concurrent", 34'hC3, 34'hC3, 8, 1, 4'b1110, 5, 1'b1, 7'd4);
    xfer("p4_after_write", 34'hAB, 34'hB, 4, 1, 4'b1110, 0, 1'b0, '0);

    // Reset while bit 3 is on the wire.
    cfg(7'd8, 2'd1, 3'd1);
    @(negedge clk);
    recv_val = 1'b1; recv_msg = 34'hFF;
    @(posedge clk);
    #1 recv_val = 1'b0;
    pulses = 0; prev = 1'b0; n = 0;
    while (pulses < 4 && n < 500) begin
      @(negedge clk);
      n++;
      if (sclk && !prev) pulses++;
      prev = sclk;
    end
    chk("mr_reached_bit3", pulses, 4);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mr_cs", cs, 4'hF);
    chk("mr_sclk", sclk, 0);
    chk("mr_mosi", mosi, 0);
    chk("mr_send_val", send_val, 0);
    chk("mr_idle", recv_rdy, 1);
    saw_val = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (send_val) saw_val = 1'b1;
    end
    chk("mr_no_send", saw_val, 0);
    $display("xfer mid_reset: sent 0xff discarded after %0d pulses", pulses);
    xfer("after_reset", 34'h1_2345_6789, 34'h1_2345_6789, 34, 1, 4'b1110, 0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
